// File: rtl/game_ctl_if.sv
// game_ctl_if: mouse/peer/hit inputs and game status outputs of the game-flow controller
interface game_ctl_if #(
  parameter int TIMER_W = 8,
  parameter int SCORE_W = 10
);
  logic [11:0]        mouse_xpos;
  logic [11:0]        mouse_ypos;
  logic               mouse_left;
  logic               peer_ready;
  logic               target_hit;
  logic [1:0]         state;
  logic [TIMER_W-1:0] time_left;
  logic [SCORE_W-1:0] score;
  logic               game_start;
  logic               game_over;
  modport master (
    output mouse_xpos, mouse_ypos, mouse_left, peer_ready, target_hit,
    input  state, time_left, score, game_start, game_over
  );
  modport slave (
    input  mouse_xpos, mouse_ypos, mouse_left, peer_ready, target_hit,
    output state, time_left, score, game_start, game_over
  );
endinterface

// File: rtl/game_ctl.sv
// game_ctl: IDLE -> WAIT -> GAME -> SCORE flow with seconds countdown, saturating score and start/over pulses
module game_ctl #(
  parameter int CLK_HZ         = 40_000_000,
  parameter int GAME_SEC       = 30,
  parameter int SCORE_HOLD_SEC = 5,
  parameter int TIMER_W        = 8,
  parameter int SCORE_W        = 10,
  parameter int START_X        = 200,
  parameter int START_Y        = 200,
  parameter int STOP_X         = 600,
  parameter int STOP_Y         = 500,
  parameter int BTN_W          = 128,
  parameter int BTN_H          = 64
) (
  input  logic       pclk,
  input  logic       rst,
  game_ctl_if.slave  g
);
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam int HW = SCORE_HOLD_SEC > 1 ? $clog2(SCORE_HOLD_SEC) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, GAME, SCORE} state_t;
  state_t             state_q, state_d;
  logic [TIMER_W-1:0] time_q, time_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               ml_q, start_q, start_d, over_q, over_d;
  logic               click, tick, in_start, in_stop, run;
  assign click    = g.mouse_left & ~ml_q;
  assign tick     = pre_q == PW'(CLK_HZ - 1);
  assign run      = state_q == GAME || state_q == SCORE;
  assign in_start = int'(g.mouse_xpos) >= START_X && int'(g.mouse_xpos) <= START_X + BTN_W - 1 &&
                    int'(g.mouse_ypos) >= START_Y && int'(g.mouse_ypos) <= START_Y + BTN_H - 1;
  assign in_stop  = int'(g.mouse_xpos) >= STOP_X && int'(g.mouse_xpos) <= STOP_X + BTN_W - 1 &&
                    int'(g.mouse_ypos) >= STOP_Y && int'(g.mouse_ypos) <= STOP_Y + BTN_H - 1;
  always_ff @(posedge pclk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      time_q  <= '0;
      score_q <= '0;
      pre_q   <= '0;
      hold_q  <= '0;
      ml_q    <= 1'b0;
      start_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      score_q <= score_d;
      pre_q   <= pre_d;
      hold_q  <= hold_d;
      ml_q    <= g.mouse_left;
      start_q <= start_d;
      over_q  <= over_d;
    end
  // peer_ready outranks STOP in WAIT; abort outranks expiry in GAME
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = click && in_start ? WAIT : IDLE;
      WAIT:    state_d = g.peer_ready ? GAME : click && in_stop ? IDLE : WAIT;
      GAME:    state_d = click && in_stop ? IDLE : tick && time_q <= TIMER_W'(1) ? SCORE : GAME;
      SCORE:   state_d = click && in_start ? WAIT : tick && hold_q == HW'(SCORE_HOLD_SEC - 1) ? IDLE : SCORE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    start_d = state_q == WAIT && state_d == GAME;
    over_d  = state_q == GAME && state_d == SCORE;
    pre_d   = run && state_d == state_q && !tick ? pre_q + 1'b1 : '0;
    hold_d  = state_q != SCORE ? '0 : tick ? hold_q + 1'b1 : hold_q;
    time_d  = start_d ? TIMER_W'(GAME_SEC) :
              state_q != GAME ? time_q :
              state_d == IDLE ? '0 :
              tick ? time_q - 1'b1 : time_q;
    score_d = start_d ? '0 :
              state_q != GAME ? score_q :
              state_d == IDLE ? '0 :
              g.target_hit && score_q != '1 ? score_q + 1'b1 : score_q;
  end
  assign g.state      = state_q;
  assign g.time_left  = time_q;
  assign g.score      = score_q;
  assign g.game_start = start_q;
  assign g.game_over  = over_q;
endmodule

// File: tb/tb_game_ctl.sv
// tb_game_ctl: table vectors plus game/score sequences checked through an expectation queue
module tb_game_ctl;
  localparam int CLK = 10, GS = 3, HS = 2, TW = 8, SW = 3;
  localparam int GT = GS * CLK, HT = HS * CLK;
  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int n_cmp = 0, n_err = 0;
  game_ctl_if #(.TIMER_W(TW), .SCORE_W(SW)) g ();
  game_ctl #(.CLK_HZ(CLK), .GAME_SEC(GS), .SCORE_HOLD_SEC(HS), .TIMER_W(TW), .SCORE_W(SW))
    dut (.pclk(pclk), .rst(rst), .g(g));
  always #5 pclk = ~pclk;
  typedef struct packed { logic [14:0] e; logic [15:0] id; } sb_t;
  typedef struct { logic [11:0] x, y; logic l, p, h; logic [14:0] e; } vec_t;
  sb_t  sb[$];
  vec_t tv[11];
  function automatic logic [14:0] ex(int st, int tl, int sc, int gs, int go);
    return {2'(st), 8'(tl), 3'(sc), 1'(gs), 1'(go)};
  endfunction
  function automatic logic [14:0] act();
    return {g.state, g.time_left, g.score, g.game_start, g.game_over};
  endfunction
  task automatic chk(input int id, input logic [14:0] a, input logic [14:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL step %0d: got state=%0d time=%0d score=%0d start=%b over=%b, want state=%0d time=%0d score=%0d start=%b over=%b",
               id, a[14:13], a[12:5], a[4:2], a[1], a[0], e[14:13], e[12:5], e[4:2], e[1], e[0]);
    end
  endtask
  always @(posedge pclk) begin
    sb_t s;
    #1;
    if (sb.size() > 0) begin
      s = sb.pop_front();
      chk(int'(s.id), act(), s.e);
    end
  end
  task automatic step(input int id, input logic [11:0] x, input logic [11:0] y,
                      input logic l, input logic p, input logic h, input logic [14:0] e);
    g.mouse_xpos = x;
    g.mouse_ypos = y;
    g.mouse_left = l;
    g.peer_ready = p;
    g.target_hit = h;
    sb.push_back('{e: e, id: 16'(id)});
    @(posedge pclk);
    #2;
  endtask
  task automatic enter_game(input int ph, input int cur, input int sc);
    step(ph * 100, 0, 0, 0, 0, 0, ex(cur, 0, sc, 0, 0));
    if (cur == 0) begin
      step(ph * 100 + 1, 200, 263, 1, 0, 0, ex(1, 0, sc, 0, 0));
      step(ph * 100 + 2, 0, 0, 0, 0, 0, ex(1, 0, sc, 0, 0));
    end
    step(ph * 100 + 3, 0, 0, 0, 1, 0, ex(2, GS, 0, 1, 0));
  endtask
  task automatic game_run(input int ph, input int last, input int ab_k, input int miss_k, input logic [31:0] hits);
    int sc = 0;
    for (int k = 1; k <= last; k++) begin
      bit ab = k == ab_k;
      bit ms = k == miss_k;
      if (!ab && hits[k] && sc != 7) sc++;
      step(ph * 100 + k, ab ? 12'd727 : ms ? 12'd728 : 12'd0, (ab || ms) ? 12'd563 : 12'd0,
           ab || ms, 1'b0, hits[k],
           ab ? ex(0, 0, 0, 0, 0) : ex(k == GT ? 3 : 2, GS - k / CLK, sc, 0, k == GT ? 1 : 0));
    end
  endtask
  task automatic score_hold(input int ph, input int n, input int click_j, input int sc);
    for (int j = 1; j <= n; j++) begin
      bit ck = j == click_j;
      step(ph * 100 + j, ck ? 12'd327 : 12'd0, ck ? 12'd263 : 12'd0, ck, 1'b0, j == 3,
           ck ? ex(1, 0, sc, 0, 0) : ex(j == HT ? 0 : 3, 0, sc, 0, 0));
    end
  endtask
  initial begin
    tv[0]  = '{12'd200, 12'd200, 1'b1, 1'b0, 1'b0, ex(1, 0, 0, 0, 0)};
    tv[1]  = '{12'd0,   12'd0,   1'b0, 1'b0, 1'b1, ex(1, 0, 0, 0, 0)};
    tv[2]  = '{12'd599, 12'd500, 1'b1, 1'b0, 1'b0, ex(1, 0, 0, 0, 0)};
    tv[3]  = '{12'd0,   12'd0,   1'b0, 1'b0, 1'b0, ex(1, 0, 0, 0, 0)};
    tv[4]  = '{12'd600, 12'd500, 1'b1, 1'b0, 1'b0, ex(0, 0, 0, 0, 0)};
    tv[5]  = '{12'd0,   12'd0,   1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0)};
    tv[6]  = '{12'd328, 12'd263, 1'b1, 1'b0, 1'b1, ex(0, 0, 0, 0, 0)};
    tv[7]  = '{12'd0,   12'd0,   1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0)};
    tv[8]  = '{12'd327, 12'd263, 1'b1, 1'b0, 1'b0, ex(1, 0, 0, 0, 0)};
    tv[9]  = '{12'd600, 12'd500, 1'b1, 1'b0, 1'b0, ex(1, 0, 0, 0, 0)};
    tv[10] = '{12'd600, 12'd500, 1'b0, 1'b1, 1'b0, ex(2, GS, 0, 1, 0)};
    g.mouse_xpos = '0;
    g.mouse_ypos = '0;
    g.mouse_left = 1'b0;
    g.peer_ready = 1'b0;
    g.target_hit = 1'b0;
    #2 rst = 1'b0;
    #1 chk(1, act(), ex(0, 0, 0, 0, 0));
    repeat (2) @(posedge pclk);
    #2 rst = 1'b1;
    @(posedge pclk);
    #2;
    foreach (tv[i]) step(10 + i, tv[i].x, tv[i].y, tv[i].l, tv[i].p, tv[i].h, tv[i].e);
    game_run(1, GT, 0, 0, (1 << 3) | (1 << 7) | (1 << 12) | (1 << 20) | (1 << 30));
    score_hold(2, HT, 0, 5);
    enter_game(3, 0, 5);
    game_run(4, GT, 0, 0, 32'h1FE | (1 << 30));
    score_hold(5, 5, 5, 7);
    enter_game(6, 1, 7);
    game_run(7, 4, 4, 0, (1 << 2) | (1 << 4));
    enter_game(8, 0, 0);
    game_run(9, CLK, CLK, 3, 1 << 5);
    step(950, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));
    enter_game(10, 0, 0);
    game_run(11, 5, 0, 0, (1 << 1) | (1 << 2) | (1 << 4));
    rst = 1'b0;
    #1 chk(2, act(), ex(0, 0, 0, 0, 0));
    repeat (2) @(posedge pclk);
    #1 chk(3, act(), ex(0, 0, 0, 0, 0));
    rst = 1'b1;
    @(posedge pclk);
    #1 chk(4, act(), ex(0, 0, 0, 0, 0));
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL queue: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
